inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the R-type CPU datapath.
- Owns the fetch PC, issues word requests to instruction memory over a req/ack handshake, and buffers returned words in a small prefetch FIFO.
- Presents {PC, Inst_code} to the decode/register-file stage over a valid/ready handshake.
- Accepts a redirect (jump/branch target) that flushes the buffer and restarts fetch.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset; low 2 bits must be 0.
- FIFO_DEPTH, 2, prefetch buffer entries; legal values 2, 4, 8.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- imem_req  output  1  instruction memory request.
- imem_addr  output  32  byte address of requested word, always word-aligned.
- imem_ack  input  1  memory returns data this cycle for the pending request.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- inst_valid  output  1  FIFO head holds an instruction.
- inst_ready  input  1  downstream consumes the head when inst_valid=1.
- Inst_code  output  32  instruction word at FIFO head.
- PC  output  32  address of Inst_code.
- redirect  input  1  load new fetch address, flush buffer.
- redirect_pc  input  32  new fetch address; bits [1:0] forced to 0 internally.

Behaviour:
- Reset values (rst=0, asynchronous):
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0, Inst_code=0, PC=RESET_PC.
  - fetch_pc=RESET_PC, FIFO count=0, FSM=IDLE.
- FSM states: IDLE, REQ, DROP.
  - IDLE -> REQ when count < FIFO_DEPTH and redirect=0.
  - REQ:
    - imem_req=1, imem_addr=fetch_pc.
    - Both signals are held stable until imem_ack=1.
    - On ack: push {fetch_pc, imem_rdata}, fetch_pc += 4.
    - After an ack, stay in REQ if (count after push/pop) < FIFO_DEPTH, else go to IDLE.
  - DROP:
    - Entered when redirect=1 while in REQ and imem_ack=0.
    - imem_req and the old imem_addr are held until ack; the returned data is discarded.
    - On ack, go to REQ (or IDLE if no space).
- imem_ack while imem_req=0 is ignored.
- Space rule: a request is issued only if a free slot exists. Only one request is outstanding at a time, so a push can never overflow.
- Output side:
  - inst_valid = (count != 0).
  - Pop when inst_valid && inst_ready.
  - Inst_code and PC are stable while inst_valid && !inst_ready.
  - Simultaneous push and pop in the same cycle keeps count unchanged.
- Latency and throughput:
  - First imem_req rises in the first clock edge after rst deasserts.
  - With zero-wait memory (ack in the same cycle as req), inst_valid rises one cycle after ack.
  - Sustained rate is 1 instruction/cycle with inst_ready held at 1.
- Redirect (highest priority):
  - On the redirect edge: FIFO is flushed (inst_valid=0 next cycle) and fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - A pop in the same cycle is treated as consumed.
  - An ack in the same cycle is discarded; the FSM goes to REQ with the new address.
  - Redirect in IDLE goes to REQ next cycle.
  - Redirect in DROP updates the target only.
- Wrap-around: fetch_pc 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- Reset mid-request: all state is cleared immediately and imem_req drops. Memory must tolerate an abandoned request.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds two outputs:
  - fetch_cnt (32 bit): increments on every pop.
  - stall_cnt (32 bit): increments every cycle with inst_valid=0 && rst=1.
  - Both counters reset to 0, wrap at 2^32, and are not cleared by redirect.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset release, zero-wait memory, inst_ready=1 -> imem_addr 0,4,8,... on consecutive cycles; PC/Inst_code stream 0x0,0x4,0x8 with matching words; one instruction per cycle after the first.
- Backpressure: inst_ready=0 with FIFO_DEPTH=2 -> exactly 2 pushes, then imem_req=0. Head holds PC=0x0 stable; releasing ready resumes at 0x8.
- Memory wait: ack delayed 3 cycles -> imem_req/imem_addr held constant for 3 cycles; single push on ack.
- Redirect with outstanding request: redirect_pc=0x0000_0103 while REQ with ack pending -> DROP. Old data is discarded; next request addr=0x100; first delivered PC=0x100; no stale instruction appears.
- Redirect coinciding with ack and pop -> FIFO empty next cycle; next imem_addr equals the redirect target.
- Wrap: redirect_pc=0xFFFF_FFFC -> delivered PCs 0xFFFF_FFFC then 0x0000_0000. Async reset asserted mid-REQ -> imem_req=0 and inst_valid=0 without waiting for clk.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - fetch PC, imem req/ack fetcher and prefetch FIFO feeding decode
// Optional FETCH_PERF_EN adds fetch_cnt/stall_cnt performance counters.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] Inst_code,
    output logic [31:0] PC,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t            state, state_nxt;
    logic [31:0]       fetch_pc;
    logic [31:0]       drop_addr;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count, count_after;
    logic [31:0]       pc_mem   [FIFO_DEPTH];
    logic [31:0]       inst_mem [FIFO_DEPTH];
    logic              push, pop, space_after;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    // A returning word is only kept when it answers a live (non-dropped) request and no redirect overrides it.
    assign push       = (state == REQ) && imem_ack && !redirect;
    assign imem_req   = (state == REQ) || (state == DROP);
    assign imem_addr  = (state == DROP) ? drop_addr : fetch_pc;
    assign Inst_code  = inst_mem[rd_ptr];
    assign PC         = pc_mem[rd_ptr];

    always_comb begin
        count_after = count;
        if (push && !pop) begin
            count_after = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_after = count - CNT_W'(1);
        end
    end

    assign space_after = (count_after < DEPTH_C);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (redirect || (count < DEPTH_C)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (redirect) begin
                    state_nxt = imem_ack ? REQ : DROP;
                end else if (imem_ack) begin
                    state_nxt = space_after ? REQ : IDLE;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_nxt = (redirect || space_after) ? REQ : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC_A;
            drop_addr <= RESET_PC_A;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
            end else if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            // The abandoned request keeps its address on the bus until memory answers it.
            if ((state == REQ) && redirect && !imem_ack) begin
                drop_addr <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_after;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pc_mem[i]   <= RESET_PC_A;
                inst_mem[i] <= 32'h0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            inst_mem[wr_ptr] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= 32'h0;
            stall_cnt <= 32'h0;
        end else begin
            if (pop) begin
                fetch_cnt <= fetch_cnt + 32'd1;
            end
            if (!inst_valid) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
